uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive half of the loopback/host serial link.
- Deserialises the `rxd` pin into bytes, LSB first, one start bit, one stop bit.
- Presents each byte on `rdata` with a one-cycle `rx_ready` strobe; flags a bad stop bit with `ferr`.
- Bit timing is identical to the transmit side, so one `CLK_PER_HALF_BIT` value serves both directions.

Parameters:
- `CLK_PER_HALF_BIT`, default 100: clock cycles per half bit period. A bit lasts 2*`CLK_PER_HALF_BIT` cycles. Legal range is 2 or more.

Ports:
- `clk` input 1: system clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `rxd` input 1: serial line, asynchronous to `clk`, idle high.
- `rdata` output 8: last received byte; holds its value until the next frame completes.
- `rx_ready` output 1: one-cycle pulse, `rdata` valid with a good stop bit.
- `ferr` output 1: one-cycle pulse, stop bit sampled low.
- `rx_busy` output 1: high while a frame is being received.

Behaviour:
- Reset (`rstn` low, asynchronous): `rdata`=0, `rx_ready`=0, `ferr`=0, `rx_busy`=0. State goes to `s_idle`. Counter=0. Synchroniser flops preset to 1.
- Input path: `rxd` passes through a 2-flop synchroniser to give `rxd_s`. A falling edge is `rxd_s` low while its previous registered value was high.
- Counter: 32-bit, clears on frame start, wraps to 0 at each sample point.
- States: `s_idle`, `s_start_bit`, `s_bit_0` .. `s_bit_7`, `s_stop_bit`.
- Frame timing, with T0 = the cycle the falling edge is detected:
  - `s_idle`: on falling edge, go to `s_start_bit`, clear the counter, set `rx_busy`=1.
  - `s_start_bit`: at T0+`CLK_PER_HALF_BIT`, sample the line.
    - If `rxd_s`=1, treat it as a glitch: return to `s_idle`, `rx_busy`=0, no strobe.
    - Otherwise go to `s_bit_0`.
  - `s_bit_k`: sample at T0+`CLK_PER_HALF_BIT`*(3+2k). Shift the sample into the shift register MSB so bit 0 lands at [0] after eight samples. Then advance to the next state.
  - `s_stop_bit`: sample at T0+19*`CLK_PER_HALF_BIT`.
    - Sample=1: `rdata` <= shift register, `rx_ready`=1 for one cycle.
    - Sample=0: `rdata` <= shift register, `ferr`=1 for one cycle, `rx_ready` stays 0.
    - Either way: `rx_busy`=0 and return to `s_idle` on the cycle after the sample.
- Latency: the strobe is registered in the cycle after the stop sample, at T0+19*`CLK_PER_HALF_BIT`+1.
- `rx_ready` and `ferr` are never high together and are never high for two consecutive cycles.
- Break or stuck-low line after a framing error: no new frame starts until `rxd_s` returns high and then falls again.
- Back-to-back frames: returning to idle at mid-stop-bit leaves half a bit of margin, so a start edge arriving immediately after the stop bit is caught.
- Edges during `s_bit_*` and `s_stop_bit` are ignored; only the sample points matter.
- Reset mid-frame aborts the frame with no strobe; all outputs go to their reset values immediately.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Every sample point (start, data and stop) takes `rxd_s` at centre-1, centre and centre+1 and uses the 2-of-3 majority.
  - Each decision, and therefore the strobe, moves one cycle later: T0+19*`CLK_PER_HALF_BIT`+2.
  - `CLK_PER_HALF_BIT` must be 3 or more.
- Undefined: single sample at centre, as described above.

Decomposition:
- Package `uart_pkg`:
  - state enum shared by TX and RX;
  - localparams for data bits (8) and frame length in half bits (20).
- Sub-module `uart_sync`: 2-flop synchroniser, reset value 1, reusable on the other asynchronous inputs.

Test Plan (`CLK_PER_HALF_BIT`=8 unless noted):
- Idle, then frame 0xA5 with stop=1 -> `rdata`=0xA5, `rx_ready` a single pulse 152+1 cycles after the synchronised edge, `ferr`=0, `rx_busy` high throughout the frame.
- Line low for 3 cycles only -> `rx_busy` rises, then falls at the mid-start check; no `rx_ready`, no `ferr`; `rdata` unchanged.
- Frame 0x3C with stop=0, line then held low for 5 bits -> `ferr` single pulse, `rdata`=0x3C, `rx_ready`=0; no second frame until the line goes high and falls again.
- Frames 0x00 then 0xFF back-to-back, one stop bit each -> two `rx_ready` pulses 160 cycles apart, `rdata` 0x00 then 0xFF.
- `rstn` low during `s_bit_3` of 0x55, released, then 0x81 sent -> no strobe for the aborted frame; `rdata`=0x81 after the next strobe.
- With `UART_RX_MAJORITY_EN`: 1-cycle high glitch exactly at the centre of bit 2 of 0x00 -> `rdata`=0x00; the same glitch without the macro gives 0x04.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the state encoding used by both TX and RX.
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int FRAME_HALF_BITS = 20;

  typedef enum logic [3:0] {
    s_idle      = 4'd0,
    s_start_bit = 4'd1,
    s_bit_0     = 4'd2,
    s_bit_1     = 4'd3,
    s_bit_2     = 4'd4,
    s_bit_3     = 4'd5,
    s_bit_4     = 4'd6,
    s_bit_5     = 4'd7,
    s_bit_6     = 4'd8,
    s_bit_7     = 4'd9,
    s_stop_bit  = 4'd10
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops preset to 1 (idle line level).
`default_nettype none

module uart_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre sampling with rx_ready / ferr strobes.
// UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decisions one cycle later.
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr,
  output logic       rx_busy
);

  localparam logic [31:0] BIT_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);

  uart_state_t          state, state_n;
  logic [31:0]          cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]           rdata_n;
  logic                 ready_n, ferr_n, busy_n;
  logic                 rxd_s, rxd_d1;
  logic                 sample_bit, sample_pt;

  uart_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxd_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rxd_d1 <= 1'b1;
    else       rxd_d1 <= rxd_s;
  end

`ifdef UART_RX_MAJORITY_EN
  // The start check waits one extra cycle so centre+1 is available; later intervals stay 2*H.
  localparam logic [31:0] START_LAST = 32'(CLK_PER_HALF_BIT);
  logic rxd_d2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rxd_d2 <= 1'b1;
    else       rxd_d2 <= rxd_d1;
  end

  assign sample_bit = (rxd_d2 & rxd_d1) | (rxd_d2 & rxd_s) | (rxd_d1 & rxd_s);
`else
  localparam logic [31:0] START_LAST = 32'(CLK_PER_HALF_BIT - 1);
  assign sample_bit = rxd_s;
`endif

  assign sample_pt = (state == s_start_bit) ? (cnt == START_LAST) : (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= s_idle;
      cnt      <= '0;
      shreg    <= '0;
      rdata    <= '0;
      rx_ready <= 1'b0;
      ferr     <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      rdata    <= rdata_n;
      rx_ready <= ready_n;
      ferr     <= ferr_n;
      rx_busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = sample_pt ? '0 : cnt + 32'd1;
    shreg_n = shreg;
    rdata_n = rdata;
    ready_n = 1'b0;
    ferr_n  = 1'b0;
    busy_n  = rx_busy;
    case (state)
      s_idle: begin
        cnt_n = '0;
        if (!rxd_s && rxd_d1) begin
          state_n = s_start_bit;
          busy_n  = 1'b1;
        end
      end
      s_start_bit: begin
        if (sample_pt) begin
          // A line back high at mid-start is a glitch, not a frame.
          if (sample_bit) begin
            state_n = s_idle;
            busy_n  = 1'b0;
          end else begin
            state_n = s_bit_0;
          end
        end
      end
      s_bit_0, s_bit_1, s_bit_2, s_bit_3,
      s_bit_4, s_bit_5, s_bit_6, s_bit_7: begin
        if (sample_pt) begin
          shreg_n = {sample_bit, shreg[DATA_BITS-1:1]};
          state_n = uart_state_t'(state + 4'd1);
        end
      end
      s_stop_bit: begin
        // Returning to idle at mid-stop leaves margin for a back-to-back start edge.
        if (sample_pt) begin
          rdata_n = shreg;
          ready_n = sample_bit;
          ferr_n  = !sample_bit;
          busy_n  = 1'b0;
          state_n = s_idle;
        end
      end
      default: begin
        state_n = s_idle;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a line-level frame model.
`default_nettype none

module tb_uart_rx;

  localparam int H = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rdata;
  logic       rx_ready, ferr, rx_busy;

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_ready (rx_ready),
    .ferr     (ferr),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (works on the raw line, one value per cycle) -------------
  typedef struct {
    int         at;
    bit         good;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  bit         m_in = 0;
  bit         m_l1 = 1, m_l2 = 1;
  int         m_n = 0, m_ok = 0;
  logic [7:0] m_byte = '0;
  logic [2:0] bpipe = '0;

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_in = 0; m_l1 = 1; m_l2 = 1; m_ok = 0; bpipe = '0;
      evq.delete();
    end else begin
      bit v, s;
      int rel;
      ev_t e;
      v = rxd;
      if (!m_in) begin
        if (!v && m_l1 && cyc >= m_ok) begin
          m_in = 1;
          m_n  = cyc;
        end
      end else begin
        rel = cyc - m_n - MAJ;
        s   = (MAJ != 0) ? maj3(m_l2, m_l1, v) : v;
        if (rel == H) begin
          if (s) begin m_in = 0; m_ok = cyc + 1; end
        end else if (rel >= 3*H && rel <= 17*H && ((rel - H) % (2*H)) == 0) begin
          m_byte[(rel - 3*H) / (2*H)] = s;
        end else if (rel == 19*H) begin
          e.at = cyc + 3; e.good = s; e.data = m_byte;
          evq.push_back(e);
          m_in = 0;
          m_ok = cyc + 1;
        end
      end
      bpipe = {bpipe[1:0], m_in};
      m_l2 = m_l1;
      m_l1 = v;
    end
    cyc++;
  end

  // ---------------- per-cycle output checker ------------------------------------------------
  logic [7:0] exp_rdata = '0;
  int n_ready = 0, n_ferr = 0, last_ready = 0, prev_ready = 0;

  always @(negedge clk) begin
    if (rstn) begin
      bit er, ef;
      ev_t e;
      er = 0; ef = 0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        er = e.good; ef = !e.good; exp_rdata = e.data;
      end
      check_val("rx_ready", 32'(rx_ready), 32'(er));
      check_val("ferr", 32'(ferr), 32'(ef));
      check_val("rdata", 32'(rdata), 32'(exp_rdata));
      check_val("rx_busy", 32'(rx_busy), 32'(bpipe[2]));
      if (rx_ready) begin n_ready++; prev_ready = last_ready; last_ready = cyc; end
      if (ferr) n_ferr++;
    end else begin
      exp_rdata = '0;
    end
  end

  // ---------------- stimulus ----------------------------------------------------------------
  task automatic line(input bit v, input int n);
    repeat (n) begin @(negedge clk); rxd = v; end
  endtask

  // gbit/goff select a one-cycle inverted level inside a data bit (gbit < 0: none).
  task automatic send(input logic [7:0] b, input bit stop, input int gbit, input int goff,
                      output int start_cyc);
    @(negedge clk); rxd = 1'b0; start_cyc = cyc;
    line(1'b0, 2*H - 1);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 2*H; j++) begin
        @(negedge clk);
        rxd = (k == gbit && j == goff) ? ~b[k] : b[k];
      end
    line(stop, 2*H);
  endtask

  initial begin
    int st, r0, f0;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_rdata", 32'(rdata), 32'h0);
    check_val("rst_ready", 32'(rx_ready), 32'h0);
    check_val("rst_ferr", 32'(ferr), 32'h0);
    check_val("rst_busy", 32'(rx_busy), 32'h0);
    @(negedge clk); rstn = 1'b1;
    line(1'b1, 20);

    // Clean frame and its latency from the synchronised edge
    send(8'hA5, 1'b1, -1, 0, st);
    line(1'b1, 10);
    check_val("a5_data", 32'(rdata), 32'hA5);
    check_val("a5_latency", 32'(last_ready - (st + 2)), 32'(19*H + 1));

    // Short low glitch: busy blips, no strobe
    r0 = n_ready; f0 = n_ferr;
    line(1'b0, 3);
    line(1'b1, 4*H);
    check_val("glitch_ready", 32'(n_ready), 32'(r0));
    check_val("glitch_rdata", 32'(rdata), 32'hA5);

    // Framing error, then a long break; nothing starts until the line recovers
    send(8'h3C, 1'b0, -1, 0, st);
    line(1'b0, 10*H);
    check_val("fe_count", 32'(n_ferr), 32'(f0 + 1));
    check_val("fe_rdata", 32'(rdata), 32'h3C);
    check_val("fe_busy", 32'(rx_busy), 32'h0);
    line(1'b1, 4*H);

    // Back-to-back frames
    r0 = n_ready;
    send(8'h00, 1'b1, -1, 0, st);
    send(8'hFF, 1'b1, -1, 0, st);
    line(1'b1, 4*H);
    check_val("b2b_count", 32'(n_ready), 32'(r0 + 2));
    check_val("b2b_spacing", 32'(last_ready - prev_ready), 32'(20*H));
    check_val("b2b_rdata", 32'(rdata), 32'hFF);

    // Reset in the middle of bit 3 of 0x55
    r0 = n_ready;
    b = 8'h55;
    @(negedge clk); rxd = 1'b0;
    line(1'b0, 2*H - 1);
    for (int k = 0; k < 3; k++) line(b[k], 2*H);
    line(b[3], H);
    check_val("mid_busy", 32'(rx_busy), 32'h1);
    rstn = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(rx_busy), 32'h0);
    check_val("mid_rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk); rxd = 1'b1;
    line(1'b1, 2);
    rstn = 1'b1;
    line(1'b1, 2*H);
    check_val("abort_ready", 32'(n_ready), 32'(r0));
    send(8'h81, 1'b1, -1, 0, st);
    line(1'b1, 10);
    check_val("after_rst_data", 32'(rdata), 32'h81);

    // One-cycle high glitch at the centre of bit 2
    send(8'h00, 1'b1, 2, H, st);
    line(1'b1, 10);
    check_val("centre_glitch", 32'(rdata), (MAJ != 0) ? 32'h00 : 32'h04);

    // Random frames, stop bits, gaps and in-bit glitches
    for (int i = 0; i < 30; i++) begin
      int gb, go;
      b  = 8'($urandom);
      gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      go = int'($urandom_range(0, 2*H - 1));
      send(b, ($urandom_range(0, 4) != 0), gb, go, st);
      line(1'b1, int'($urandom_range(0, 3*H)));
      if ($urandom_range(0, 5) == 0) begin
        line(1'b0, int'($urandom_range(1, H)));
        line(1'b1, 3*H);
      end
    end
    line(1'b1, 24*H);
    check_val("queue_drained", 32'(evq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
